// File: rtl/mips_muldiv_unit_if.sv
// Bundle between the execute-stage decoder and the multiply/divide sequencer.
// The decoder side uses the master modport and the unit uses the slave modport.
interface mips_muldiv_unit_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int HI_LO_SEL_WIDTH = 2
);
  logic                       start_i;
  logic [1:0]                 op_i;
  logic [DATA_WIDTH-1:0]      rs_data_i;
  logic [DATA_WIDTH-1:0]      rt_data_i;
  logic [HI_LO_SEL_WIDTH-1:0] mt_sel_i;
  logic [DATA_WIDTH-1:0]      mt_data_i;
  logic                       mf_req_i;
  logic                       flush_i;
  logic                       busy_o;
  logic                       done_o;
  logic                       stall_o;
  logic [DATA_WIDTH-1:0]      hi_o;
  logic [DATA_WIDTH-1:0]      lo_o;

  modport master (
    output start_i, op_i, rs_data_i, rt_data_i, mt_sel_i, mt_data_i, mf_req_i, flush_i,
    input  busy_o, done_o, stall_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, rs_data_i, rt_data_i, mt_sel_i, mt_data_i, mf_req_i, flush_i,
    output busy_o, done_o, stall_o, hi_o, lo_o
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Define MIPS_MULDIV_SINGLE_CYCLE_MULT_EN to compute multiplies in one cycle.
module mips_muldiv_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int HI_LO_SEL_WIDTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  mips_muldiv_unit_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             is_div_reg;
  logic             div_zero_reg;
  logic             neg_lo_reg;
  logic             neg_hi_reg;
  logic [DW-1:0]    operand_reg;
  logic [DW-1:0]    acc_hi_reg;
  logic [DW-1:0]    acc_lo_reg;
  logic [DW-1:0]    hi_reg;
  logic [DW-1:0]    lo_reg;

  // Operand preparation: signed ops work on magnitudes, signs are fixed up in FIX.
  logic          sgn_op;
  logic          is_mult;
  logic          rs_neg;
  logic          rt_neg;
  logic [DW-1:0] rs_mag;
  logic [DW-1:0] rt_mag;

  assign sgn_op  = ~bus.op_i[0];
  assign is_mult = ~bus.op_i[1];
  assign rs_neg  = sgn_op & bus.rs_data_i[DW-1];
  assign rt_neg  = sgn_op & bus.rt_data_i[DW-1];
  assign rs_mag  = rs_neg ? -bus.rs_data_i : bus.rs_data_i;
  assign rt_mag  = rt_neg ? -bus.rt_data_i : bus.rt_data_i;

`ifdef MIPS_MULDIV_SINGLE_CYCLE_MULT_EN
  logic [2*DW-1:0] fast_prod;
  assign fast_prod = {{DW{rs_neg}}, bus.rs_data_i} * {{DW{rt_neg}}, bus.rt_data_i};
`endif

  // One iteration: multiply keeps the product in {acc_hi, acc_lo} shifting right,
  // divide keeps remainder in acc_hi and shifts dividend/quotient left through acc_lo.
  logic [DW:0]   mul_sum;
  logic [DW:0]   rem_shift;
  logic [DW:0]   rem_diff;
  logic [DW-1:0] acc_hi_next;
  logic [DW-1:0] acc_lo_next;

  always_comb begin
    mul_sum     = {1'b0, acc_hi_reg} + {1'b0, (acc_lo_reg[0] ? operand_reg : {DW{1'b0}})};
    rem_shift   = {acc_hi_reg, acc_lo_reg[DW-1]};
    rem_diff    = rem_shift - {1'b0, operand_reg};
    acc_hi_next = mul_sum[DW:1];
    acc_lo_next = {mul_sum[0], acc_lo_reg[DW-1:1]};
    if (is_div_reg) begin
      if (!rem_diff[DW]) begin
        acc_hi_next = rem_diff[DW-1:0];
        acc_lo_next = {acc_lo_reg[DW-2:0], 1'b1};
      end else begin
        acc_hi_next = rem_shift[DW-1:0];
        acc_lo_next = {acc_lo_reg[DW-2:0], 1'b0};
      end
    end
  end

  logic [2*DW-1:0] prod_abs;
  logic [2*DW-1:0] prod_fix;
  logic [DW-1:0]   quot_fix;
  logic [DW-1:0]   rem_fix;

  always_comb begin
    prod_abs = {acc_hi_reg, acc_lo_reg};
    prod_fix = neg_lo_reg ? -prod_abs : prod_abs;
    quot_fix = neg_lo_reg ? -acc_lo_reg : acc_lo_reg;
    // Divide by zero: the remainder path already yields the dividend, only LO is forced.
    if (div_zero_reg) quot_fix = {DW{1'b1}};
    rem_fix  = neg_hi_reg ? -acc_hi_reg : acc_hi_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      is_div_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
      neg_lo_reg   <= 1'b0;
      neg_hi_reg   <= 1'b0;
      operand_reg  <= '0;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start_i) begin
            busy_reg     <= 1'b1;
            is_div_reg   <= ~is_mult;
            div_zero_reg <= ~is_mult & (bus.rt_data_i == '0);
            neg_hi_reg   <= ~is_mult & rs_neg;
`ifdef MIPS_MULDIV_SINGLE_CYCLE_MULT_EN
            if (is_mult) begin
              {acc_hi_reg, acc_lo_reg} <= fast_prod;
              neg_lo_reg <= 1'b0;
              done_reg   <= 1'b1;
              state_reg  <= FIX;
            end else
`endif
            begin
              neg_lo_reg  <= rs_neg ^ rt_neg;
              acc_hi_reg  <= '0;
              acc_lo_reg  <= is_mult ? rt_mag : rs_mag;
              operand_reg <= is_mult ? rs_mag : rt_mag;
              cnt_reg     <= CW'(DW - 1);
              state_reg   <= RUN;
            end
          end else begin
            if (bus.mt_sel_i[0]) lo_reg <= bus.mt_data_i;
            if (bus.mt_sel_i[1]) hi_reg <= bus.mt_data_i;
          end
        end
        RUN: begin
          if (bus.flush_i) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            if (cnt_reg == '0) begin
              state_reg <= FIX;
              done_reg  <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
        end
        FIX: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          if (!bus.flush_i) begin
            if (is_div_reg) begin
              hi_reg <= rem_fix;
              lo_reg <= quot_fix;
            end else begin
              hi_reg <= prod_fix[2*DW-1:DW];
              lo_reg <= prod_fix[DW-1:0];
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o  = busy_reg;
  assign bus.done_o  = done_reg;
  assign bus.hi_o    = hi_reg;
  assign bus.lo_o    = lo_reg;
  assign bus.stall_o = busy_reg & (bus.mf_req_i | bus.start_i | (bus.mt_sel_i != '0));
endmodule
